// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default byte width, default
// receive FIFO depth and the width helper for occupancy counters.
package uart_pkg;

   // Byte width produced by the UART receiver.
   localparam int UART_DATA_WIDTH = 8;

   // Default number of entries in the receive FIFO.
   localparam int UART_FIFO_DEPTH = 16;

   // An occupancy counter must hold 0..depth inclusive, so it needs one bit
   // more than a pointer into a power-of-two array of that depth.
   function automatic int uart_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: DEPTH x DATA_WIDTH registers with
// one synchronous write port and one asynchronous (combinational) read port.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = UART_FIFO_DEPTH,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Write one entry per cycle; reset clears every entry so the head byte
   // reads as zero while the FIFO is empty after reset.
   // NOTE: resetting the array costs a reset net on every storage flop; it is
   // kept because the empty FIFO must present a defined m_data of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: non-blocking assignment for all clocked state, so every
            // register samples its pre-edge value regardless of statement order.
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Head-of-queue read is purely combinational from the read address.
   assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. Each rx_done strobe
// pushes one byte into a circular FIFO; bytes leave over a valid/ready
// stream. A byte arriving while the FIFO is full and not being read is
// dropped and recorded in the sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = UART_DATA_WIDTH,
   parameter int DEPTH       = UART_FIFO_DEPTH,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              rx_done,
   input  logic [DATA_WIDTH-1:0]             rx_data_in,
   output logic [DATA_WIDTH-1:0]             m_data,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [uart_cnt_width(DEPTH)-1:0]  count,
   output logic                              almost_full,
   output logic                              overrun,
   input  logic                              overrun_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = uart_cnt_width(DEPTH);

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overrun_q, overrun_d;

   logic full;
   logic push;
   logic pop;
   logic drop;

   // Handshake decode. A full FIFO can still take a byte in the cycle its
   // head is read, because the pop frees the slot the push will fill.
   assign full = (count_q == FULL_CNT);
   assign pop  = m_valid & m_ready;
   assign push = rx_done & (~full | pop);
   assign drop = rx_done & full & ~pop;

   // Next-state logic for pointers, occupancy and the sticky overrun flag.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      // Pointers are exactly log2(DEPTH) bits, so DEPTH-1 + 1 wraps to 0.
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear must still leave the flag set,
      // otherwise that lost byte would go unreported.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   // State registers; reset empties the FIFO immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   uart_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (rx_data_in),
      .raddr (rd_ptr_q),
      .rdata (m_data)
   );

   // All status outputs come from registered state only; none depends on
   // m_ready or rx_done in the same cycle.
   assign m_valid     = (count_q != '0);
   assign count       = count_q;
   assign almost_full = (count_q >= AFULL_CNT);
   assign overrun     = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue-based reference model in the
// monitor tracks the expected contents; directed scenarios and a random phase
// drive the inputs.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          rx_done;
   logic [DW-1:0] rx_data_in;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          overrun;
   logic          overrun_clr;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   // Reference model: expected FIFO contents in order, plus the sticky flag.
   logic [DW-1:0] exp_q[$];
   logic          ovr_m;
   int            sz;
   logic          pop_m;
   logic          drop_m;

   uart_rx_fifo #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_done     (rx_done),
      .rx_data_in  (rx_data_in),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .count       (count),
      .almost_full (almost_full),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus, applied shortly after a rising edge.
   task automatic drive(input logic done, input logic [DW-1:0] d, input logic rdy, input logic clr);
      @(posedge clk);
      #1;
      rx_done     = done;
      rx_data_in  = d;
      m_ready     = rdy;
      overrun_clr = clr;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
      idle();
   endtask

   // Monitor: on the falling edge compare the DUT against the model, then
   // advance the model by the inputs the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         ovr_m = 1'b0;
      end else begin
         sz = exp_q.size();
         check("count", 32'(count), 32'(sz));
         check("m_valid", 32'(m_valid), 32'(sz != 0));
         check("almost_full", 32'(almost_full), 32'(sz >= AFULL));
         check("overrun", 32'(overrun), 32'(ovr_m));
         if (sz != 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
         pop_m  = (sz != 0) && m_ready;
         drop_m = rx_done && (sz == DEPTH) && !pop_m;
         if (pop_m) begin
            void'(exp_q.pop_front());
            n_pops++;
         end
         if (rx_done && !drop_m) exp_q.push_back(rx_data_in);
         if (drop_m) ovr_m = 1'b1;
         else if (overrun_clr) ovr_m = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pops0;
      rst_n       = 1'b0;
      rx_done     = 1'b0;
      rx_data_in  = '0;
      m_ready     = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_almost_full", 32'(almost_full), 0);
      check("rst_overrun", 32'(overrun), 0);

      // Three pushes held, then read out in order.
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
      idle();
      check("three_count", 32'(count), 3);
      check("three_head", 32'(m_data), 32'h A5);
      drain(3);
      check("three_empty", 32'(m_valid), 0);

      // Fill to full, watch almost_full threshold, then overflow by one.
      for (int i = 0; i < 11; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      idle();
      check("af_below", 32'(almost_full), 0);
      drive(1'b1, 8'h0B, 1'b0, 1'b0);
      idle();
      check("af_at_level", 32'(almost_full), 1);
      for (int i = 12; i < 16; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      idle();
      check("drop_count", 32'(count), 16);
      check("drop_overrun", 32'(overrun), 1);
      drain(16);
      check("drop_drained", 32'(count), 0);
      drive(1'b0, '0, 1'b0, 1'b1);
      idle();
      check("clr_overrun", 32'(overrun), 0);

      // Full FIFO written and read in the same cycle.
      for (int i = 0; i < 16; i++) drive(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      idle();
      check("rw_full_count", 32'(count), 16);
      check("rw_full_overrun", 32'(overrun), 0);
      drain(16);

      // Drop coinciding with clear keeps the flag; a lone clear removes it.
      for (int i = 0; i < 16; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      idle();
      check("ovr_set", 32'(overrun), 1);
      drive(1'b1, 8'h22, 1'b0, 1'b1);
      idle();
      check("ovr_set_wins", 32'(overrun), 1);
      drive(1'b0, '0, 1'b0, 1'b1);
      idle();
      check("ovr_cleared", 32'(overrun), 0);
      drain(16);

      // 40 bytes streamed with m_ready toggling; pointers wrap twice.
      pops0 = n_pops;
      for (int i = 0; i < 80; i++)
         drive(1'(i % 2 == 0), DW'($urandom), 1'(i % 2 == 1), 1'b0);
      idle();
      check("wrap_pops", 32'(n_pops - pops0), 40);
      check("wrap_overrun", 32'(overrun), 0);

      // Random traffic, including drops and occasional clears.
      for (int i = 0; i < 600; i++)
         drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 15) == 0));
      drain(20);
      check("rand_drained", 32'(count), 0);
      drive(1'b0, '0, 1'b0, 1'b1);
      idle();

      // Asynchronous reset mid-cycle with five bytes stored.
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      idle();
      check("pre_rst_count", 32'(count), 5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 0);
      check("async_rst_valid", 32'(m_valid), 0);
      check("async_rst_data", 32'(m_data), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1'b1, 8'h12, 1'b0, 1'b0);
      idle();
      check("post_rst_data", 32'(m_data), 32'h12);
      check("post_rst_count", 32'(count), 1);
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures every byte the receiver presents with its one-cycle done strobe and stores the bytes in a circular FIFO. It presents the bytes to the host logic over a valid/ready stream, and flags overflow when the host falls behind the serial line.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; matches receiver output width
- DEPTH, 16, FIFO entries; power of two, >= 2
- AFULL_LEVEL, 12, almost_full asserts when occupancy >= this value; range 1..DEPTH

Ports:
- clk  in  1  single system clock; everything is sampled on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_done  in  1  write strobe from receiver; each high cycle is one push
- rx_data_in  in  DATA_WIDTH  byte from receiver; valid only while rx_done = 1
- m_data  out  DATA_WIDTH  head-of-FIFO byte
- m_valid  out  1  FIFO non-empty; m_data is valid
- m_ready  in  1  consumer accepts m_data this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AFULL_LEVEL
- overrun  out  1  sticky flag: a byte was dropped
- overrun_clr  in  1  synchronous clear of overrun

## Operation
- pop = m_valid & m_ready. Data moves only on pop; holding m_ready high while empty has no effect.
- push = rx_done & (count < DEPTH | pop).
  - A full FIFO still accepts a write in the same cycle it is read.
  - Storage is written at wr_ptr.
- Drop: rx_done & count == DEPTH & !pop.
  - The byte is discarded and overrun is set.
  - wr_ptr and count are unchanged.
- rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or on neither
- m_data = mem[rd_ptr], a combinational read of the storage array.
- m_valid = (count != 0).
- overrun:
  - Set on drop.
  - Cleared by overrun_clr.
  - Drop and clear in the same cycle leaves overrun = 1 (set wins).
- No bypass path: a byte pushed into an empty FIFO cannot be popped in the same cycle.
- There is no state machine. Behaviour is defined entirely by the pointer and count registers.

## Timing
- Reset values, asynchronous on rst_n low:
  - rd_ptr = 0, wr_ptr = 0, count = 0
  - m_valid = 0, almost_full = 0, overrun = 0
  - all storage = 0, so m_data = 0
- Reset mid-operation discards all stored bytes immediately. The first rx_done after rst_n rises is a normal push.
- Write latency: a push at edge N gives m_valid = 1 and m_data = that byte from edge N, i.e. visible in cycle N+1.
- After a pop at edge N, m_data shows the next entry in cycle N+1. m_valid falls in cycle N+1 if that pop emptied the FIFO.
- count, almost_full and overrun are registered, or derived from registered count only. None has a combinational path from an input.
- m_valid and m_data have no combinational dependence on m_ready or rx_done.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Shared package uart_pkg:
  - UART_DATA_WIDTH = 8
  - default UART_FIFO_DEPTH = 16
  - the count-width helper function
- One sub-module, uart_fifo_mem:
  - DEPTH x DATA_WIDTH register array
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - storage reset by rst_n
- uart_rx_fifo holds the pointers, count, flags and push/pop logic.

## Test plan
- Reset, then 3 pushes (0xA5, 0x3C, 0xFF) with m_ready = 0 -> count = 3, m_valid = 1, m_data = 0xA5. Then m_ready = 1 for 3 cycles -> outputs 0xA5, 0x3C, 0xFF in order; count = 0; m_valid = 0.
- DEPTH = 16: push 0x00..0x0F -> almost_full rises on the cycle count reaches 12. A 17th push of 0x55 -> dropped, overrun = 1, count = 16. Draining yields 0x00..0x0F only.
- Full FIFO, rx_done with 0x77 and m_ready = 1 in the same cycle -> count stays 16, overrun stays 0, 0x77 is read out last.
- Wrap-around: 40 bytes streamed with m_ready toggling 1/0 -> all 40 received in order, no overrun, pointers wrap at least twice.
- overrun set, then overrun_clr pulsed in the same cycle as a fresh drop -> overrun = 1. overrun_clr alone on the next cycle -> overrun = 0.
- rst_n pulsed low asynchronously, mid-clock, with count = 5 -> count = 0 and m_valid = 0 immediately. Next push of 0x12 -> m_data = 0x12 in the following cycle.
